// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg: GF(2^8) helpers and byte/column types for the AES MixColumns datapath.
// Contents: AES_POLY reduction constant, gf_byte_t / gf_col_t types,
// xtime, gf_mul2, gf_mul3 and, with INV_MIX_COLUMNS_EN, gf_mul9/11/13/14.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0] gf_byte_t;
    // Element [3] is a0 (bits 31:24), element [0] is a3 (bits 7:0).
    typedef logic [3:0][7:0] gf_col_t;

    function automatic gf_byte_t xtime(input gf_byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic gf_byte_t gf_mul2(input gf_byte_t x);
        return xtime(x);
    endfunction

    function automatic gf_byte_t gf_mul3(input gf_byte_t x);
        return xtime(x) ^ x;
    endfunction

`ifdef INV_MIX_COLUMNS_EN
    // The inverse coefficients decompose into x, 2x, 4x and 8x terms.
    function automatic gf_byte_t gf_mul9(input gf_byte_t x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic gf_byte_t gf_mul11(input gf_byte_t x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic gf_byte_t gf_mul13(input gf_byte_t x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic gf_byte_t gf_mul14(input gf_byte_t x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction
`endif

endpackage

// File: rtl/mix_column_word.sv
// mix_column_word: combinational MixColumns of one 32-bit AES column.
// Ports: col (a0 in [31:24] .. a3 in [7:0]), col_out (same packing),
// inv (only with INV_MIX_COLUMNS_EN) selects InvMixColumns.
module mix_column_word
    import aes_gf_pkg::*;
(
`ifdef INV_MIX_COLUMNS_EN
    input  logic        inv,
`endif
    input  logic [31:0] col,
    output logic [31:0] col_out
);

    gf_col_t a;
    gf_col_t fwd;

    assign a = col;

    assign fwd = {gf_mul2(a[3]) ^ gf_mul3(a[2]) ^ a[1] ^ a[0],
                  a[3] ^ gf_mul2(a[2]) ^ gf_mul3(a[1]) ^ a[0],
                  a[3] ^ a[2] ^ gf_mul2(a[1]) ^ gf_mul3(a[0]),
                  gf_mul3(a[3]) ^ a[2] ^ a[1] ^ gf_mul2(a[0])};

`ifdef INV_MIX_COLUMNS_EN
    gf_col_t rev;

    assign rev = {gf_mul14(a[3]) ^ gf_mul11(a[2]) ^ gf_mul13(a[1]) ^ gf_mul9(a[0]),
                  gf_mul9(a[3]) ^ gf_mul14(a[2]) ^ gf_mul11(a[1]) ^ gf_mul13(a[0]),
                  gf_mul13(a[3]) ^ gf_mul9(a[2]) ^ gf_mul14(a[1]) ^ gf_mul11(a[0]),
                  gf_mul11(a[3]) ^ gf_mul13(a[2]) ^ gf_mul9(a[1]) ^ gf_mul14(a[0])};

    assign col_out = inv ? rev : fwd;
`else
    assign col_out = fwd;
`endif

endmodule

// File: rtl/mix_columns_calc.sv
// mix_columns_calc: registered AES MixColumns over COLS (1 or 4) columns, 1-cycle latency.
// Ports: clk, rst_n (async active-low), in_valid, col [32*COLS-1:0] (column k at [32k+31:32k]),
// out_valid, col_out. Macro INV_MIX_COLUMNS_EN adds inv, sampled with in_valid.
module mix_columns_calc #(
    parameter int COLS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
`ifdef INV_MIX_COLUMNS_EN
    input  logic                 inv,
`endif
    input  logic [32*COLS-1:0]   col,
    output logic                 out_valid,
    output logic [32*COLS-1:0]   col_out
);

    logic [32*COLS-1:0] mixed;

    for (genvar k = 0; k < COLS; k++) begin : g_col
        mix_column_word u_word (
`ifdef INV_MIX_COLUMNS_EN
            .inv     (inv),
`endif
            .col     (col[32*k +: 32]),
            .col_out (mixed[32*k +: 32])
        );
    end

    // col_out only loads on in_valid, so idle-cycle garbage on col never reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            col_out   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                col_out <= mixed;
        end
    end

endmodule

// File: tb/tb_mix_columns_calc.sv
// tb_mix_columns_calc: scoreboard bench for mix_columns_calc with COLS=1 and COLS=4 instances.
module tb_mix_columns_calc;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [31:0]  col1;
    logic [127:0] col4;
    logic         out_valid1;
    logic         out_valid4;
    logic [31:0]  col_out1;
    logic [127:0] col_out4;
`ifdef INV_MIX_COLUMNS_EN
    logic         inv;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0]  q1[$];
    logic [127:0] q4[$];
    logic [31:0]  last1 = '0;
    logic [127:0] last4 = '0;

    mix_columns_calc #(.COLS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef INV_MIX_COLUMNS_EN
        .inv       (inv),
`endif
        .col       (col1),
        .out_valid (out_valid1),
        .col_out   (col_out1)
    );

    mix_columns_calc #(.COLS(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef INV_MIX_COLUMNS_EN
        .inv       (inv),
`endif
        .col       (col4),
        .out_valid (out_valid4),
        .col_out   (col_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference multiply by shift-and-add, independent of the RTL decomposition.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] mixm(input logic [31:0] c, input logic iv);
        logic [7:0] m[4];
        logic [31:0] r = '0;
        if (iv) begin
            m[0] = 8'h0E; m[1] = 8'h0B; m[2] = 8'h0D; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[31-8*i -: 8] = r[31-8*i -: 8] ^ gmul(c[31-8*j -: 8], m[(j-i+4)%4]);
        return r;
    endfunction

    function automatic logic [127:0] mix4(input logic [127:0] c, input logic iv);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = mixm(c[32*k +: 32], iv);
        return r;
    endfunction

    task automatic step(input logic v, input logic [31:0] c1, input logic [31:0] e1,
                        input logic [127:0] c4, input logic [127:0] e4);
        in_valid = v;
        col1 = c1;
        col4 = c4;
        if (v) begin
            q1.push_back(e1);
            q4.push_back(e4);
        end
        @(posedge clk);
        #1;
        check("out_valid1", {127'b0, out_valid1}, {127'b0, v});
        check("out_valid4", {127'b0, out_valid4}, {127'b0, v});
        if (v) begin
            last1 = q1.pop_front();
            last4 = q4.pop_front();
            check("col_out1", {96'b0, col_out1}, {96'b0, last1});
            check("col_out4", col_out4, last4);
        end else begin
            check("hold1", {96'b0, col_out1}, {96'b0, last1});
            check("hold4", col_out4, last4);
        end
    endtask

    logic [31:0] vin[6]  = '{32'hDB135345, 32'hF20A225C, 32'h01010101,
                             32'hC6C6C6C6, 32'hD4D4D4D5, 32'h2D26314C};
    logic [31:0] vout[6] = '{32'h8E4DA1BC, 32'h9FDC589D, 32'h01010101,
                             32'hC6C6C6C6, 32'hD5D5D7D6, 32'h4D7EBDF8};

    initial begin
        logic [31:0] r1;
        logic [127:0] r4;
        rst_n = 1'b0;
        in_valid = 1'b0;
        col1 = '0;
        col4 = '0;
`ifdef INV_MIX_COLUMNS_EN
        inv = 1'b0;
`endif
        #12;
        check("rst_valid1", {127'b0, out_valid1}, 128'd0);
        check("rst_col1", {96'b0, col_out1}, 128'd0);
        check("rst_col4", col_out4, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // one vector at a time, each followed by an idle cycle with junk on col
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vin[i], vout[i], {4{vin[i]}}, {4{vout[i]}});
            step(1'b0, 32'hFFFFFFFF, 32'h0, {4{32'hFFFFFFFF}}, 128'h0);
        end

        // back-to-back
        for (int i = 0; i < 6; i++)
            step(1'b1, vin[i], vout[i], {vin[i], vin[(i+1)%6], vin[(i+2)%6], vin[(i+3)%6]},
                 {vout[i], vout[(i+1)%6], vout[(i+2)%6], vout[(i+3)%6]});

        step(1'b1, 32'hDB135345, 32'h8E4DA1BC,
             128'hDB135345_F20A225C_01010101_C6C6C6C6,
             128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6);
        step(1'b0, 32'hFFFFFFFF, 32'h0, {4{32'hFFFFFFFF}}, 128'h0);

        for (int i = 0; i < 16; i++) begin
            r1 = $urandom;
            r4 = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, r1, mixm(r1, 1'b0), r4, mix4(r4, 1'b0));
        end

`ifdef INV_MIX_COLUMNS_EN
        inv = 1'b1;
        step(1'b1, 32'h8E4DA1BC, 32'hDB135345, {4{32'h8E4DA1BC}}, {4{32'hDB135345}});
        step(1'b1, 32'h4D7EBDF8, 32'h2D26314C, {4{32'h4D7EBDF8}}, {4{32'h2D26314C}});
        for (int i = 0; i < 8; i++) begin
            inv = i[0];
            r1 = $urandom;
            r4 = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, r1, mixm(r1, inv), r4, mix4(r4, inv));
        end
        inv = 1'b0;
`endif

        // asynchronous reset while a result is valid
        step(1'b1, vin[5], vout[5], {4{vin[5]}}, {4{vout[5]}});
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid1", {127'b0, out_valid1}, 128'd0);
        check("arst_valid4", {127'b0, out_valid4}, 128'd0);
        check("arst_col1", {96'b0, col_out1}, 128'd0);
        check("arst_col4", col_out4, 128'd0);
        last1 = '0;
        last4 = '0;
        in_valid = 1'b1;
        col1 = vin[0];
        @(posedge clk);
        #1;
        check("rst_held_valid1", {127'b0, out_valid1}, 128'd0);
        check("rst_held_col1", {96'b0, col_out1}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'hFFFFFFFF, 32'h0, {4{32'hFFFFFFFF}}, 128'h0);
        step(1'b0, 32'h12345678, 32'h0, {4{32'h12345678}}, 128'h0);
        step(1'b1, vin[1], vout[1], {4{vin[1]}}, {4{vout[1]}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
